// File: rtl/link_tx_arbiter.sv
// Packet-granular round-robin arbiter that feeds NREQ requesters onto one outbound link.
// It keeps a credit count for the downstream receive buffer and emits one registered flit per cycle.
module link_tx_arbiter #(
  parameter int WIDTH   = 64,
  parameter int NREQ    = 4,
  parameter int CREDITS = 16
) (
  input  logic                      tx_clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      tx_ready,
  input  logic                      credit_ret,
  output logic [WIDTH-1:0]          tx_par_data,
  output logic                      tx_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      credit_err
);

  localparam int GW = $clog2(NREQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);

  logic [0:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic [GW-1:0] next_ptr;
  logic          found;
  logic [7:0]    credits;
  logic          can_send;
  logic          xfer;

  assign busy     = (state == SEND);
  assign can_send = (state == SEND) && tx_ready && (credits != 8'd0);
  assign xfer     = can_send && req_valid[grant_id];
  assign next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    req_ready = '0;
    if (can_send) req_ready[grant_id] = 1'b1;
  end

  // First requester with valid set, searching upward from rr_ptr and wrapping.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        pick  = GW'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      credits     <= CREDIT_MAX;
      tx_par_data <= '0;
      tx_valid    <= 1'b0;
      credit_err  <= 1'b0;
    end else begin
      tx_valid    <= xfer;
      tx_par_data <= xfer ? req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;

      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer && req_last[grant_id]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase

      // A transfer and a credit return in the same cycle cancel out.
      if (xfer && !credit_ret) begin
        credits <= credits - 8'd1;
      end else if (credit_ret && !xfer) begin
        if (credits == CREDIT_MAX) credit_err <= 1'b1;
        else                       credits    <= credits + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter with NREQ=4, CREDITS=4, WIDTH=64.
// The scenarios cover single and multi-flit packets, round-robin order, credit starvation, link stalls, credit errors and mid-packet reset.
module tb_link_tx_arbiter;

  localparam int WIDTH   = 64;
  localparam int NREQ    = 4;
  localparam int CREDITS = 4;

  logic                  tx_clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_ready;
  logic                  credit_ret;
  logic [WIDTH-1:0]      tx_par_data;
  logic                  tx_valid;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  credit_err;

  int n_asserts = 0;
  int n_fail    = 0;

  link_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CREDITS(CREDITS)) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_ready    (tx_ready),
    .credit_ret  (credit_ret),
    .tx_par_data (tx_par_data),
    .tx_valid    (tx_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .credit_err  (credit_err)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic set_flit(input int k, input logic [63:0] d, input logic last);
    req_data[k*WIDTH +: WIDTH] = d;
    req_last[k]                = last;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    credit_ret = 1'b0;
    tx_ready   = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req_data = '0;
    do_reset();
    tick();
    rst = 1'b1;
    tick();

    // Reset values
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", tx_par_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    check("rst_credits", 64'(dut.credits), 64'd4);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Requester 2, three-flit packet A,B,C
    req_valid = 4'b0100;
    set_flit(2, 64'hAAAA_0000_0000_000A, 1'b0);
    #1 check("p3_ready_idle", 64'(req_ready), 64'd0);
    tick();
    check("p3_grant", 64'(grant_id), 64'd2);
    check("p3_busy", 64'(busy), 64'd1);
    check("p3_no_flit_yet", 64'(tx_valid), 64'd0);
    check("p3_req_ready", 64'(req_ready), 64'b0100);
    tick();
    check("p3_flit_a", tx_par_data, 64'hAAAA_0000_0000_000A);
    check("p3_valid_a", 64'(tx_valid), 64'd1);
    set_flit(2, 64'hBBBB_0000_0000_000B, 1'b0);
    tick();
    check("p3_flit_b", tx_par_data, 64'hBBBB_0000_0000_000B);
    set_flit(2, 64'hCCCC_0000_0000_000C, 1'b1);
    tick();
    check("p3_flit_c", tx_par_data, 64'hCCCC_0000_0000_000C);
    check("p3_busy_fall", 64'(busy), 64'd0);
    check("p3_credits", 64'(dut.credits), 64'd1);
    req_valid = '0;
    tick();
    check("p3_idle_valid", 64'(tx_valid), 64'd0);
    check("p3_idle_data", tx_par_data, 64'd0);

    // rr_ptr is now 3: requesters 0 and 3 both request, 3 wins
    req_valid = 4'b1001;
    set_flit(0, 64'h0, 1'b1);
    set_flit(3, 64'h3, 1'b1);
    tick();
    check("rr_after_2", 64'(grant_id), 64'd3);
    do_reset();
    check("rst_grant_clear", 64'(grant_id), 64'd0);
    check("rst_busy_clear", 64'(busy), 64'd0);

    // All four requesters post single-flit packets
    for (int k = 0; k < NREQ; k++) set_flit(k, 64'hD000 + 64'(k), 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      check("rr_grant", 64'(grant_id), 64'(k));
      check("rr_gap", 64'(tx_valid), 64'd0);
      tick();
      check("rr_data", tx_par_data, 64'hD000 + 64'(k));
      check("rr_valid", 64'(tx_valid), 64'd1);
      req_valid[k] = 1'b0;
    end
    check("rr_credits_zero", 64'(dut.credits), 64'd0);
    set_flit(0, 64'hD0D0, 1'b1);
    req_valid[0] = 1'b1;
    credit_ret   = 1'b1;
    tick();
    check("rr_wrap_grant", 64'(grant_id), 64'd0);
    check("rr_wrap_credit", 64'(dut.credits), 64'd1);
    credit_ret = 1'b0;
    tick();
    check("rr_wrap_data", tx_par_data, 64'hD0D0);
    do_reset();

    // Six-flit packet starves on credits
    req_valid = 4'b0010;
    set_flit(1, 64'hF1, 1'b0);
    tick();
    check("cr_grant", 64'(grant_id), 64'd1);
    for (int f = 1; f <= 4; f++) begin
      tick();
      check("cr_flit", tx_par_data, 64'hF0 + 64'(f));
      set_flit(1, 64'hF0 + 64'(f + 1), 1'b0);
    end
    check("cr_credits_zero", 64'(dut.credits), 64'd0);
    #1 check("cr_ready_blocked", 64'(req_ready), 64'd0);
    tick();
    check("cr_stalled", 64'(tx_valid), 64'd0);
    credit_ret = 1'b1;
    tick();
    check("cr_still_stalled", 64'(tx_valid), 64'd0);
    credit_ret = 1'b0;
    #1 check("cr_ready_back", 64'(req_ready), 64'b0010);
    tick();
    check("cr_flit5", tx_par_data, 64'hF5);
    check("cr_flit5_valid", 64'(tx_valid), 64'd1);
    set_flit(1, 64'hF6, 1'b1);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    tick();
    check("cr_flit6", tx_par_data, 64'hF6);
    check("cr_done", 64'(busy), 64'd0);
    do_reset();

    // Link stall for three cycles mid-packet
    req_valid = 4'b1000;
    set_flit(3, 64'h61, 1'b0);
    tick();
    tick();
    check("st_g1", tx_par_data, 64'h61);
    check("st_credits_g1", 64'(dut.credits), 64'd3);
    set_flit(3, 64'h62, 1'b0);
    tx_ready = 1'b0;
    #1 check("st_ready_low", 64'(req_ready), 64'd0);
    for (int s = 0; s < 3; s++) begin
      credit_ret = (s == 1);
      tick();
      check("st_no_valid", 64'(tx_valid), 64'd0);
      check("st_grant_hold", 64'(grant_id), 64'd3);
      check("st_credits", 64'(dut.credits), (s >= 1) ? 64'd4 : 64'd3);
    end
    credit_ret = 1'b0;
    tx_ready   = 1'b1;
    tick();
    check("st_g2", tx_par_data, 64'h62);
    check("st_credits_g2", 64'(dut.credits), 64'd3);
    set_flit(3, 64'h63, 1'b1);
    credit_ret = 1'b1;
    tick();
    check("st_g3", tx_par_data, 64'h63);
    check("both_credit_same", 64'(dut.credits), 64'd3);
    check("st_busy_fall", 64'(busy), 64'd0);
    req_valid = '0;
    tick();
    check("ret_to_max", 64'(dut.credits), 64'd4);
    check("ret_no_err", 64'(credit_err), 64'd0);
    tick();
    check("over_ret_credits", 64'(dut.credits), 64'd4);
    check("over_ret_err", 64'(credit_err), 64'd1);
    credit_ret = 1'b0;
    tick();
    check("err_sticky", 64'(credit_err), 64'd1);

    // Reset after flit 2 of a five-flit packet
    do_reset();
    check("err_cleared", 64'(credit_err), 64'd0);
    req_valid = 4'b0001;
    set_flit(0, 64'h71, 1'b0);
    tick();
    tick();
    check("mr_h1", tx_par_data, 64'h71);
    set_flit(0, 64'h72, 1'b0);
    tick();
    check("mr_h2", tx_par_data, 64'h72);
    set_flit(0, 64'h73, 1'b0);
    rst = 1'b1;
    tick();
    check("mr_valid", 64'(tx_valid), 64'd0);
    check("mr_data", tx_par_data, 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_grant", 64'(grant_id), 64'd0);
    check("mr_credits", 64'(dut.credits), 64'd4);
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mr_no_more_flits", 64'(tx_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
